// File: rtl/dht_sensor_reader.sv
// dht_sensor_reader: open-drain DHT11/DHT22 reader with a 1 us
// timebase, pulse-width bit decode, checksum check and retry.
module dht_sensor_reader #(
  parameter int CLK_FREQ_HZ        = 100_000_000,
  parameter int START_LOW_US_DHT11 = 18000,
  parameter int START_LOW_US_DHT22 = 1000,
  parameter int TIMEOUT_US         = 200,
  parameter int BIT_THRESH_US      = 50,
  parameter int MAX_RETRY          = 2,
  parameter int RETRY_GAP_US       = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode,
  inout  wire         dht_io,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic        timeout_err,
  output logic        checksum_err,
  output logic [39:0] frame,
  output logic [15:0] humidity,
  output logic [15:0] temperature,
  output logic [3:0]  state_dbg
);

  localparam int DIV_RAW = CLK_FREQ_HZ / 1_000_000;
  localparam int DIV = (DIV_RAW > 0) ? DIV_RAW : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [19:0] LOW11 = 20'(START_LOW_US_DHT11);
  localparam logic [19:0] LOW22 = 20'(START_LOW_US_DHT22);
  localparam logic [19:0] TMO = 20'(TIMEOUT_US);
  localparam logic [19:0] GAP = 20'(RETRY_GAP_US);
  localparam logic [20:0] THRESH = 21'(BIT_THRESH_US);
  localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_START_LOW = 4'd1,
    S_REL       = 4'd2,
    S_RESP_L    = 4'd3,
    S_RESP_H    = 4'd4,
    S_BIT_L     = 4'd5,
    S_BIT_H     = 4'd6,
    S_CHECK     = 4'd7,
    S_FAIL      = 4'd8,
    S_GAP       = 4'd9
  } state_t;

  state_t state;

  logic [DW-1:0] div_cnt;
  logic          us_tick;
  logic [19:0]   us_cnt;
  logic          s1;
  logic          s2;
  logic          s3;
  logic          rise;
  logic          fall;
  logic          tmo;
  logic [20:0]   hi_us;
  logic          bit_val;
  logic [19:0]   low_us;
  logic          drive_low;
  logic          mode_q;
  logic [2:0]    retry;
  logic [5:0]    bit_cnt;
  logic [39:0]   shreg;
  logic          cks_fail;
  logic [7:0]    sum;
  logic          sum_ok;

  // Open drain: only ever pull low or release.
  assign dht_io = drive_low ? 1'b0 : 1'bz;
  assign state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= dht_io;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) div_cnt <= '0;
    else if (us_tick) div_cnt <= '0;
    else div_cnt <= div_cnt + DW'(1);
  end

  assign us_tick = (div_cnt == DIV_LAST);
  assign tmo = (us_cnt >= TMO);
  assign low_us = mode_q ? LOW22 : LOW11;

  // Count the tick of the decoding edge too, so both edges of
  // a high pulse are measured with the same synchronizer lag.
  assign hi_us = {1'b0, us_cnt} + {20'd0, us_tick};
  assign bit_val = (hi_us > THRESH);

  assign sum = shreg[39:32] + shreg[31:24]
             + shreg[23:16] + shreg[15:8];
  assign sum_ok = (sum == shreg[7:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      us_cnt       <= '0;
      drive_low    <= 1'b0;
      mode_q       <= 1'b0;
      retry        <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      cks_fail     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      valid        <= 1'b0;
      timeout_err  <= 1'b0;
      checksum_err <= 1'b0;
      frame        <= '0;
      humidity     <= '0;
      temperature  <= '0;
    end else begin
      done <= 1'b0;
      if (us_tick && us_cnt != '1) us_cnt <= us_cnt + 20'd1;
      unique case (state)
        S_IDLE: begin
          // done is high on the first IDLE cycle; start is
          // ignored there.
          if (start && !done) begin
            state        <= S_START_LOW;
            us_cnt       <= '0;
            drive_low    <= 1'b1;
            busy         <= 1'b1;
            mode_q       <= mode;
            retry        <= '0;
            bit_cnt      <= '0;
            valid        <= 1'b0;
            timeout_err  <= 1'b0;
            checksum_err <= 1'b0;
          end
        end
        S_START_LOW: begin
          if (us_cnt >= low_us) begin
            state     <= S_REL;
            us_cnt    <= '0;
            drive_low <= 1'b0;
          end
        end
        S_REL: begin
          if (fall) begin
            state  <= S_RESP_L;
            us_cnt <= '0;
          end else if (tmo) begin
            state    <= S_FAIL;
            us_cnt   <= '0;
            cks_fail <= 1'b0;
          end
        end
        S_RESP_L: begin
          if (rise) begin
            state  <= S_RESP_H;
            us_cnt <= '0;
          end else if (tmo) begin
            state    <= S_FAIL;
            us_cnt   <= '0;
            cks_fail <= 1'b0;
          end
        end
        S_RESP_H: begin
          if (fall) begin
            state  <= S_BIT_L;
            us_cnt <= '0;
          end else if (tmo) begin
            state    <= S_FAIL;
            us_cnt   <= '0;
            cks_fail <= 1'b0;
          end
        end
        S_BIT_L: begin
          if (rise) begin
            state  <= S_BIT_H;
            us_cnt <= '0;
          end else if (tmo) begin
            state    <= S_FAIL;
            us_cnt   <= '0;
            cks_fail <= 1'b0;
          end
        end
        S_BIT_H: begin
          if (fall) begin
            shreg   <= {shreg[38:0], bit_val};
            bit_cnt <= bit_cnt + 6'd1;
            us_cnt  <= '0;
            state   <= (bit_cnt == 6'd39) ? S_CHECK : S_BIT_L;
          end else if (tmo) begin
            state    <= S_FAIL;
            us_cnt   <= '0;
            cks_fail <= 1'b0;
          end
        end
        S_CHECK: begin
          us_cnt <= '0;
          if (sum_ok) begin
            frame       <= shreg;
            humidity    <= shreg[39:24];
            temperature <= shreg[23:8];
            valid       <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else begin
            cks_fail <= 1'b1;
            state    <= S_FAIL;
          end
        end
        S_FAIL: begin
          us_cnt <= '0;
          if (retry < RETRY_MAX) begin
            retry <= retry + 3'd1;
            state <= S_GAP;
          end else begin
            timeout_err  <= ~cks_fail;
            checksum_err <= cks_fail;
            done         <= 1'b1;
            busy         <= 1'b0;
            state        <= S_IDLE;
          end
        end
        S_GAP: begin
          if (us_cnt >= GAP) begin
            state     <= S_START_LOW;
            us_cnt    <= '0;
            drive_low <= 1'b1;
            bit_cnt   <= '0;
          end
        end
        default: begin
          state     <= S_IDLE;
          drive_low <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dht_sensor_reader.sv
// tb_dht_sensor_reader: directed vectors against a behavioural
// DHT sensor model on the open-drain line.
module tb_dht_sensor_reader;

  localparam int DIV = 2;
  localparam int L11 = 180;
  localparam int L22 = 100;
  localparam int TMO = 200;
  localparam int GAP = 300;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  wire         dht_line;
  logic        busy;
  logic        done;
  logic        valid;
  logic        timeout_err;
  logic        checksum_err;
  logic [39:0] frame;
  logic [15:0] humidity;
  logic [15:0] temperature;
  logic [3:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  logic        sen_low = 1'b0;
  bit          sen_busy = 1'b0;
  bit          sen_hi = 1'b0;
  int          sen_bit = -1;
  bit          respond = 1'b0;
  bit          bnd = 1'b0;
  logic [39:0] tx = '0;

  int done_cnt = 0;
  int low_q[$];
  int rel_q[$];
  int gap_q[$];

  typedef struct {
    bit          mode;
    bit          respond;
    bit          bnd;
    logic [39:0] tx;
    int          low_us;
    bit          e_valid;
    bit          e_cks;
    bit          e_tmo;
    int          e_starts;
    logic [39:0] e_frame;
    logic [15:0] e_hum;
    logic [15:0] e_tmp;
  } tv_t;

  tv_t vec[5];

  always #5 clk = ~clk;

  pullup (dht_line);
  assign dht_line = sen_low ? 1'b0 : 1'bz;

  dht_sensor_reader #(
    .CLK_FREQ_HZ(2_000_000),
    .START_LOW_US_DHT11(L11),
    .START_LOW_US_DHT22(L22),
    .TIMEOUT_US(TMO),
    .BIT_THRESH_US(50),
    .MAX_RETRY(2),
    .RETRY_GAP_US(GAP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .mode(mode),
    .dht_io(dht_line),
    .busy(busy),
    .done(done),
    .valid(valid),
    .timeout_err(timeout_err),
    .checksum_err(checksum_err),
    .frame(frame),
    .humidity(humidity),
    .temperature(temperature),
    .state_dbg(state_dbg)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act,
                         input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic wait_us(input int n);
    repeat (n * DIV) @(negedge clk);
  endtask

  function automatic int hi_time(input int i);
    logic b;
    b = tx[39-i];
    if (bnd) return b ? 51 : ((i % 2 == 1) ? 50 : 49);
    return b ? 70 : 26;
  endfunction

  task automatic send_frame();
    sen_busy = 1'b1;
    wait_us(30);
    sen_low = 1'b1;
    wait_us(80);
    sen_low = 1'b0;
    wait_us(80);
    for (int i = 0; i < 40; i++) begin
      sen_bit = i;
      sen_hi = 1'b0;
      sen_low = 1'b1;
      wait_us(24);
      sen_low = 1'b0;
      sen_hi = 1'b1;
      wait_us(hi_time(i));
    end
    sen_hi = 1'b0;
    sen_low = 1'b1;
    wait_us(24);
    sen_low = 1'b0;
    sen_bit = -1;
    sen_busy = 1'b0;
  endtask

  // Sensor: measure each host start pulse, then answer if enabled.
  initial begin : sensor
    int n;
    forever begin
      @(negedge clk);
      if (dht_line === 1'b0 && !sen_low) begin
        n = 0;
        while (dht_line === 1'b0) begin
          n++;
          @(negedge clk);
        end
        low_q.push_back(n);
        if (respond) send_frame();
      end
    end
  end

  initial begin : monitor
    int rr;
    int gr;
    rr = 0;
    gr = 0;
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (state_dbg == 4'd2) rr++;
      else if (rr != 0) begin
        rel_q.push_back(rr);
        rr = 0;
      end
      if (state_dbg == 4'd9) gr++;
      else if (gr != 0) begin
        gap_q.push_back(gr);
        gr = 0;
      end
    end
  end

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40000 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic wait_sen();
    int i;
    i = 0;
    while (sen_busy && i < 20000) begin
      @(negedge clk);
      i++;
    end
    chk("sensor_idle", sen_busy, 0);
  endtask

  task automatic run_vec(input tv_t tv);
    int n_low;
    int n_rel;
    int n_gap;
    int d0;
    bit seen;
    respond = tv.respond;
    bnd = tv.bnd;
    tx = tv.tx;
    n_low = low_q.size();
    n_rel = rel_q.size();
    n_gap = gap_q.size();
    d0 = done_cnt;
    @(negedge clk);
    mode = tv.mode;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_rise", busy, 1);
    chk("line_low", dht_line, 0);
    wait_done(seen);
    chk("done_seen", seen, 1);
    chk("busy_at_done", busy, 0);
    chk("valid", valid, tv.e_valid);
    chk("checksum_err", checksum_err, tv.e_cks);
    chk("timeout_err", timeout_err, tv.e_tmo);
    chk("frame", frame, tv.e_frame);
    chk("humidity", humidity, tv.e_hum);
    chk("temperature", temperature, tv.e_tmp);
    wait_sen();
    repeat (20) @(negedge clk);
    chk("done_once", done_cnt - d0, 1);
    chk("starts", low_q.size() - n_low, tv.e_starts);
    chk("gaps", gap_q.size() - n_gap, tv.e_starts - 1);
    for (int i = n_low; i < low_q.size(); i++)
      chk_rng("start_low", low_q[i], 2 * tv.low_us - 2, 2 * tv.low_us + 2);
    for (int i = n_gap; i < gap_q.size(); i++)
      chk_rng("retry_gap", gap_q[i], 2 * GAP - 2, 2 * GAP + 4);
    if (!tv.respond)
      for (int i = n_rel; i < rel_q.size(); i++)
        chk_rng("rel_timeout", rel_q[i], 2 * TMO - 4, 2 * TMO + 4);
  endtask

  initial begin : main
    int i;
    vec[0] = '{1'b0, 1'b1, 1'b0, 40'h35_00_18_00_4D, L11,
               1'b1, 1'b0, 1'b0, 1,
               40'h35_00_18_00_4D, 16'h3500, 16'h1800};
    vec[1] = '{1'b1, 1'b1, 1'b0, 40'h02_8C_01_5F_EE, L22,
               1'b1, 1'b0, 1'b0, 1,
               40'h02_8C_01_5F_EE, 16'h028C, 16'h015F};
    vec[2] = '{1'b1, 1'b1, 1'b1, 40'h01_02_03_04_0A, L22,
               1'b1, 1'b0, 1'b0, 1,
               40'h01_02_03_04_0A, 16'h0102, 16'h0304};
    vec[3] = '{1'b0, 1'b1, 1'b0, 40'h35_00_18_00_4E, L11,
               1'b0, 1'b1, 1'b0, 3,
               40'h01_02_03_04_0A, 16'h0102, 16'h0304};
    vec[4] = '{1'b1, 1'b0, 1'b0, 40'h0, L22,
               1'b0, 1'b0, 1'b1, 3,
               40'h01_02_03_04_0A, 16'h0102, 16'h0304};

    repeat (3) @(negedge clk);
    chk("rst_line", dht_line, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", valid, 0);
    chk("rst_tmo", timeout_err, 0);
    chk("rst_cks", checksum_err, 0);
    chk("rst_frame", frame, 0);
    chk("rst_hum", humidity, 0);
    chk("rst_tmp", temperature, 0);
    chk("rst_state", state_dbg, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 5; v++) run_vec(vec[v]);

    // Reset while the host is pulling the line low.
    respond = 1'b0;
    @(negedge clk);
    mode = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("sl_line_low", dht_line, 0);
    #2 reset = 1'b1;
    #1;
    chk("sl_rst_line", dht_line, 1);
    chk("sl_rst_state", state_dbg, 0);
    chk("sl_rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // Reset in the high phase of bit 20.
    respond = 1'b1;
    bnd = 1'b0;
    tx = 40'h35_00_18_00_4D;
    @(negedge clk);
    mode = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    i = 0;
    while (!(sen_bit == 20 && sen_hi) && i < 20000) begin
      @(negedge clk);
      i++;
    end
    chk("bh_reached", sen_bit, 20);
    repeat (20) @(negedge clk);
    chk("bh_state", state_dbg, 6);
    #2 reset = 1'b1;
    #1;
    chk("bh_rst_line", dht_line, 1);
    chk("bh_rst_state", state_dbg, 0);
    chk("bh_rst_busy", busy, 0);
    chk("bh_rst_done", done, 0);
    chk("bh_rst_valid", valid, 0);
    chk("bh_rst_tmo", timeout_err, 0);
    chk("bh_rst_cks", checksum_err, 0);
    chk("bh_rst_frame", frame, 0);
    chk("bh_rst_hum", humidity, 0);
    chk("bh_rst_tmp", temperature, 0);
    @(negedge clk);
    reset = 1'b0;
    wait_sen();
    repeat (10) @(negedge clk);
    run_vec(vec[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
